// File: rtl/seq_shift_add_mult_if.sv
// Handshake and data bundle for seq_shift_add_mult: request side drives START/A/B,
// the multiplier returns P/READY/DONE.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic                 START;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   P;
    logic                 READY;
    logic                 DONE;

    modport master (output START, A, B, input P, READY, DONE);
    modport slave  (input START, A, B, output P, READY, DONE);
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one add and one right shift per cycle, WIDTH cycles per product.
// Define SIGNED_MULT_EN to build the two's-complement variant; otherwise unsigned only.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                CK,
    input  logic                RN,
    seq_shift_add_mult_if.slave bus
);
    localparam int                 CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);
    localparam logic [0:0]         IDLE  = 1'b0;
    localparam logic [0:0]         RUN   = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        mcand;
    logic [WIDTH-1:0]        mplier;
    logic signed [WIDTH:0]   acc;
    logic [2*WIDTH-1:0]      p;
    logic                    done;

    logic                    last;
    logic signed [WIDTH:0]   addend;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0]        mplier_nx;

    always_comb begin
        last   = (cnt == LAST);
        addend = '0;
`ifdef SIGNED_MULT_EN
        if (mplier[0]) addend = {mcand[WIDTH-1], mcand};
        // The multiplier MSB has negative weight, so its partial product is subtracted.
        sum    = last ? (acc - addend) : (acc + addend);
        acc_nx = {sum[WIDTH], sum[WIDTH:1]};
`else
        if (mplier[0]) addend = {1'b0, mcand};
        sum    = acc + addend;
        acc_nx = {1'b0, sum[WIDTH:1]};
`endif
        // Bit shifted out of the accumulator becomes the next product bit above the multiplier.
        mplier_nx = {sum[0], mplier[WIDTH-1:1]};
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        mcand  <= bus.A;
                        mplier <= bus.B;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nx;
                    mplier <= mplier_nx;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        p     <= {acc_nx[WIDTH-1:0], mplier_nx};
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.P     = p;
    assign bus.READY = (state == IDLE);
    assign bus.DONE  = done;
endmodule
